// File: rtl/vram_arbiter.sv
// Arbitrates one single-port VRAM between the display fetcher (default owner) and the CPU.
// Define VRAM_ARB_STARVE_GUARD_EN to add the CPU starvation guard.
module vram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int CPU_MAX_WAIT = 64
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_gnt,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    output logic                  disp_rvalid,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  disp_overrun
);

    logic force_cpu;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

    logic [7:0] wait_cnt;
    logic       overrun_q;

    assign force_cpu = (wait_cnt == MAX_WAIT);

    // wait_cnt counts consecutive refused CPU cycles; it cannot pass MAX_WAIT
    // because the forced slot grants a pending CPU request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (cpu_req && !cpu_gnt) wait_cnt <= wait_cnt + 8'd1;
            else                     wait_cnt <= '0;
            if (force_cpu && cpu_req && disp_req) overrun_q <= 1'b1;
        end
    end

    assign disp_overrun = overrun_q;
`else
    logic unused_max_wait;
    assign unused_max_wait = (CPU_MAX_WAIT != 0);
    assign force_cpu       = 1'b0;
    assign disp_overrun    = 1'b0;
`endif

    // Stage 0: combinational grant, held off while reset is asserted
    always_comb begin
        disp_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        if (RST_N) begin
            if (force_cpu && cpu_req) cpu_gnt  = 1'b1;
            else if (disp_req)        disp_gnt = 1'b1;
            else if (cpu_req)         cpu_gnt  = 1'b1;
        end
    end

    logic vld_p1, cpu_p1, rd_p1;
    logic vld_p2, cpu_p2, rd_p2;

    // Stage 1: RAM command and first return tag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            vld_p1    <= 1'b0;
            cpu_p1    <= 1'b0;
            rd_p1     <= 1'b0;
        end else begin
            ram_en <= disp_gnt | cpu_gnt;
            ram_we <= cpu_gnt & cpu_we;
            if (disp_gnt) begin
                ram_addr <= disp_addr;
            end else if (cpu_gnt) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end
            vld_p1 <= disp_gnt | cpu_gnt;
            cpu_p1 <= cpu_gnt;
            rd_p1  <= disp_gnt | ~cpu_we;
        end
    end

    // Stage 2: tag aligned with the RAM read data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p2 <= 1'b0;
            cpu_p2 <= 1'b0;
            rd_p2  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            cpu_p2 <= cpu_p1;
            rd_p2  <= rd_p1;
        end
    end

    assign disp_rvalid = vld_p2 & rd_p2 & ~cpu_p2;
    assign cpu_rvalid  = vld_p2 & rd_p2 & cpu_p2;
    assign disp_rdata  = ram_rdata;
    assign cpu_rdata   = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed tables/sequences plus a randomized run
// against a cycle-stamped expectation model with its own shadow memory.
module tb_vram_arbiter;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXW = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_gnt;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_we = 1'b0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          disp_overrun;

    vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .disp_overrun(disp_overrun)
    );

    always #5 CLK = ~CLK;

    // Initial VRAM contents: 0x0010 holds 0xBEEF, every other word holds addr^0xFFFF.
    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hFFFF);
    endfunction

    // VRAM macro model: data appears in the cycle after ram_en is sampled.
    bit          ram_wr  [0:65535];
    logic [15:0] ram_mem [0:65535];
    logic [15:0] ram_q = '0;
    assign ram_rdata = ram_q;

    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_wdata;
                ram_wr[ram_addr]  <= 1'b1;
            end else begin
                ram_q <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drive_idle();
        end
    endtask

    task automatic cpu_read_test(input string tag);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_we = 1'b0;
        @(negedge CLK);
        chk({tag, "_gnt"}, {disp_gnt, cpu_gnt}, 2'b01);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge CLK);
        chk({tag, "_ram"}, {ram_en, ram_we, ram_addr}, {2'b10, 16'h0010});
        chk({tag, "_early_rvalid"}, cpu_rvalid, 1'b0);
        next_cycle();
        @(negedge CLK);
        chk({tag, "_rvalid"}, {disp_rvalid, cpu_rvalid}, 2'b01);
        chk({tag, "_rdata"}, cpu_rdata, 16'hBEEF);
        next_cycle();
        @(negedge CLK);
        chk({tag, "_rvalid_end"}, cpu_rvalid, 1'b0);
    endtask

    typedef struct {
        logic d;
        logic c;
        logic we;
        logic exp_dg;
        logic exp_cg;
    } vec_t;

    vec_t tbl [6];

    // Randomized-run reference state
    bit          ref_wr  [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        acc_v   [4];
    logic        acc_we  [4];
    logic [15:0] acc_addr[4];
    logic [15:0] acc_wd  [4];
    logic        ret_v   [4];
    logic        ret_cpu [4];
    logic [15:0] ret_data[4];

    initial begin
        tbl[0] = '{d: 1'b0, c: 1'b0, we: 1'b0, exp_dg: 1'b0, exp_cg: 1'b0};
        tbl[1] = '{d: 1'b1, c: 1'b0, we: 1'b0, exp_dg: 1'b1, exp_cg: 1'b0};
        tbl[2] = '{d: 1'b0, c: 1'b1, we: 1'b0, exp_dg: 1'b0, exp_cg: 1'b1};
        tbl[3] = '{d: 1'b0, c: 1'b1, we: 1'b1, exp_dg: 1'b0, exp_cg: 1'b1};
        tbl[4] = '{d: 1'b1, c: 1'b1, we: 1'b0, exp_dg: 1'b1, exp_cg: 1'b0};
        tbl[5] = '{d: 1'b1, c: 1'b1, we: 1'b1, exp_dg: 1'b1, exp_cg: 1'b0};

        // Reset state, with both requests asserted to show grants are blocked
        disp_req = 1'b1; cpu_req = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_gnt", {disp_gnt, cpu_gnt}, 2'b00);
        chk("rst_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 34'h0);
        chk("rst_flags", {disp_rvalid, cpu_rvalid, disp_overrun}, 3'b000);
        next_cycle();
        drive_idle();
        RST_N = 1'b1;
        idle(2);

        // Single-cycle grant table from an idle state
        for (int i = 0; i < 6; i++) begin
            logic [15:0] exp_addr;
            next_cycle();
            disp_req = tbl[i].d; disp_addr = 16'h0100 + 16'(i);
            cpu_req = tbl[i].c; cpu_addr = 16'h0200 + 16'(i);
            cpu_we = tbl[i].we; cpu_wdata = 16'hA500 + 16'(i);
            @(negedge CLK);
            chk($sformatf("tbl%0d_gnt", i), {disp_gnt, cpu_gnt}, {tbl[i].exp_dg, tbl[i].exp_cg});
            exp_addr = tbl[i].exp_dg ? disp_addr : cpu_addr;
            next_cycle();
            disp_req = 1'b0;
            cpu_req = tbl[i].c & ~tbl[i].exp_cg;
            @(negedge CLK);
            chk($sformatf("tbl%0d_ram_en", i), ram_en, tbl[i].exp_dg | tbl[i].exp_cg);
            chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].exp_cg & tbl[i].we);
            if (tbl[i].exp_dg | tbl[i].exp_cg)
                chk($sformatf("tbl%0d_ram_addr", i), ram_addr, exp_addr);
            if (cpu_req)
                chk($sformatf("tbl%0d_cpu_next_slot", i), cpu_gnt, 1'b1);
            idle(3);
        end

        cpu_read_test("cpu_read");
        idle(2);

        // Contention: display wins, CPU takes the next free slot
        next_cycle();
        disp_req = 1'b1; disp_addr = 16'h0020;
        cpu_req = 1'b1; cpu_addr = 16'h0030; cpu_we = 1'b0;
        @(negedge CLK);
        chk("cont_t0_gnt", {disp_gnt, cpu_gnt}, 2'b10);
        next_cycle();
        disp_req = 1'b0;
        @(negedge CLK);
        chk("cont_t1_gnt", {disp_gnt, cpu_gnt}, 2'b01);
        chk("cont_t1_ram", {ram_en, ram_addr}, {1'b1, 16'h0020});
        next_cycle();
        cpu_req = 1'b0;
        @(negedge CLK);
        chk("cont_t2_rvalid", {disp_rvalid, cpu_rvalid}, 2'b10);
        chk("cont_t2_rdata", disp_rdata, 16'hFFDF);
        next_cycle();
        @(negedge CLK);
        chk("cont_t3_rvalid", {disp_rvalid, cpu_rvalid}, 2'b01);
        chk("cont_t3_rdata", cpu_rdata, 16'hFFCF);
        idle(2);

        // Back-to-back display reads 0..7
        for (int k = 0; k < 11; k++) begin
            next_cycle();
            disp_req = (k < 8);
            disp_addr = 16'(k);
            @(negedge CLK);
            if (k >= 2 && k < 10) begin
                chk($sformatf("b2b%0d_rvalid", k - 2), disp_rvalid, 1'b1);
                chk($sformatf("b2b%0d_rdata", k - 2), disp_rdata, 16'(k - 2) ^ 16'hFFFF);
            end else begin
                chk($sformatf("b2b_idle%0d_rvalid", k), disp_rvalid, 1'b0);
            end
        end
        idle(2);

        // Starvation behaviour with display held high and a CPU write pending
`ifdef VRAM_ARB_STARVE_GUARD_EN
        for (int k = 0; k < MAXW + 1; k++) begin
            next_cycle();
            disp_req = 1'b1; disp_addr = 16'h0050;
            cpu_req = 1'b1; cpu_addr = 16'h0040; cpu_we = 1'b1; cpu_wdata = 16'h1234;
            @(negedge CLK);
            chk($sformatf("guard_w%0d_gnt", k), {disp_gnt, cpu_gnt}, (k == MAXW) ? 2'b01 : 2'b10);
            chk($sformatf("guard_w%0d_ovr", k), disp_overrun, 1'b0);
        end
        next_cycle();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge CLK);
        chk("guard_ram", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 16'h0040, 16'h1234});
        chk("guard_ovr_set", disp_overrun, 1'b1);
        idle(2);
        @(negedge CLK);
        chk("guard_ovr_sticky", disp_overrun, 1'b1);
`else
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            disp_req = 1'b1; disp_addr = 16'h0050;
            cpu_req = 1'b1; cpu_addr = 16'h0040; cpu_we = 1'b1; cpu_wdata = 16'h1234;
            @(negedge CLK);
            chk($sformatf("noguard_w%0d_gnt", k), {disp_gnt, cpu_gnt}, 2'b10);
        end
        next_cycle();
        disp_req = 1'b0;
        @(negedge CLK);
        chk("noguard_release_gnt", {disp_gnt, cpu_gnt}, 2'b01);
        next_cycle();
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge CLK);
        chk("noguard_ram", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 16'h0040, 16'h1234});
        chk("noguard_ovr", disp_overrun, 1'b0);
`endif
        idle(3);

        // Reset one cycle after a read grant
        next_cycle();
        disp_req = 1'b1; disp_addr = 16'h0060;
        @(negedge CLK);
        chk("rstmid_gnt", disp_gnt, 1'b1);
        next_cycle();
        disp_req = 1'b1; cpu_req = 1'b1;
        RST_N = 1'b0;
        #1;
        chk("rstmid_gnt_blocked", {disp_gnt, cpu_gnt}, 2'b00);
        chk("rstmid_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 34'h0);
        chk("rstmid_flags", {disp_rvalid, cpu_rvalid, disp_overrun}, 3'b000);
        next_cycle();
        drive_idle();
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("rstmid_norv%0d", k), {disp_rvalid, cpu_rvalid, ram_en}, 3'b000);
            next_cycle();
        end
        cpu_read_test("post_rst_read");
        idle(3);

        // Randomized traffic against the expectation model
        begin
            bit          pend = 1'b0;
            bit          eovr = 1'b0;
            int          mwait = 0;
            logic [15:0] c_addr = '0;
            logic [15:0] c_wd = '0;
            logic        c_we = 1'b0;
            for (int s = 0; s < 4; s++) begin
                acc_v[s] = 1'b0; ret_v[s] = 1'b0;
            end
            for (int cyc = 0; cyc < 400; cyc++) begin
                int  s, s1, s2;
                bit  frc, edg, ecg;
                logic [15:0] a;
                next_cycle();
                disp_req  = ($urandom_range(0, 9) < 6);
                disp_addr = 16'($urandom_range(0, 15));
                if (!pend && $urandom_range(0, 2) != 0) begin
                    pend   = 1'b1;
                    c_addr = 16'($urandom_range(0, 15));
                    c_we   = $urandom_range(0, 1) == 1;
                    c_wd   = 16'($urandom);
                end
                cpu_req = pend; cpu_addr = c_addr; cpu_we = c_we; cpu_wdata = c_wd;
                @(negedge CLK);
                s = cyc % 4;
`ifdef VRAM_ARB_STARVE_GUARD_EN
                frc = (mwait == MAXW);
`else
                frc = 1'b0;
`endif
                ecg = pend && (frc || !disp_req);
                edg = disp_req && !ecg;
                chk("rnd_gnt", {disp_gnt, cpu_gnt}, {edg, ecg});
                chk("rnd_ram_en", ram_en, acc_v[s]);
                if (acc_v[s]) begin
                    chk("rnd_ram_cmd", {ram_we, ram_addr}, {acc_we[s], acc_addr[s]});
                    if (acc_we[s]) chk("rnd_ram_wdata", ram_wdata, acc_wd[s]);
                end
                chk("rnd_rvalid", {disp_rvalid, cpu_rvalid}, {ret_v[s] & ~ret_cpu[s], ret_v[s] & ret_cpu[s]});
                if (ret_v[s])
                    chk("rnd_rdata", ret_cpu[s] ? cpu_rdata : disp_rdata, ret_data[s]);
                chk("rnd_ovr", disp_overrun, eovr);
                acc_v[s] = 1'b0;
                ret_v[s] = 1'b0;
                if (edg || ecg) begin
                    s1 = (cyc + 1) % 4;
                    s2 = (cyc + 2) % 4;
                    a = edg ? disp_addr : c_addr;
                    acc_v[s1] = 1'b1; acc_we[s1] = ecg & c_we;
                    acc_addr[s1] = a; acc_wd[s1] = c_wd;
                    if (ecg && c_we) begin
                        ref_mem[a] = c_wd;
                        ref_wr[a]  = 1'b1;
                    end else begin
                        ret_v[s2] = 1'b1; ret_cpu[s2] = ecg;
                        ret_data[s2] = ref_wr[a] ? ref_mem[a] : init_word(a);
                    end
                end
                if (frc && pend && disp_req) eovr = 1'b1;
                mwait = (pend && !ecg) ? mwait + 1 : 0;
                if (ecg) pend = 1'b0;
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one synchronous single-port video RAM between the display scanout fetcher and the CPU bus. The display is granted by default so the pixel stream fed by the sync generator never stalls, and the CPU gets every free slot. An optional starvation guard forces a CPU slot after a bounded wait. The block sits between the scanout/line-fetch logic, the CPU memory-mapped VRAM window, and the VRAM macro.

## Interface
Parameters:
- ADDR_WIDTH, 16, VRAM word address width.
- DATA_WIDTH, 16, VRAM word width.
- CPU_MAX_WAIT, 64, CPU wait cycles before the guard forces a CPU slot. Range 1..255. Used only with the guard compiled in.

Ports:
- CLK  in  1  pixel/system clock; all logic on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request, level.
- disp_addr  in  ADDR_WIDTH  display read address, valid while disp_req.
- disp_gnt  out  1  combinational; display request accepted this cycle.
- disp_rdata  out  DATA_WIDTH  display read data.
- disp_rvalid  out  1  disp_rdata valid this cycle.
- cpu_req  in  1  CPU access request; held with addr/we/wdata stable until cpu_gnt.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  combinational; CPU request accepted this cycle.
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid this cycle; reads only.
- ram_en  out  1  registered RAM access enable.
- ram_we  out  1  registered RAM write enable.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_wdata  out  DATA_WIDTH  registered RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data. Valid in the cycle after the RAM samples ram_en.
- disp_overrun  out  1  sticky; a display request was refused by the guard.

## Operation
- Arbitration is evaluated every cycle, with at most one grant per cycle. Priority:
  - Guard force active and cpu_req: cpu_gnt=1, disp_gnt=0.
  - Else if disp_req: disp_gnt=1.
  - Else if cpu_req: cpu_gnt=1.
- The winner's addr/we/wdata are registered onto ram_* at the clock edge ending the grant cycle. ram_en=1 for exactly that one following cycle. ram_we=0 for display accesses.
- Return pipeline: a 2-stage tag shift register records (valid, owner, is_read) per grant.
  - disp_rvalid/cpu_rvalid are asserted from stage 2.
  - disp_rdata and cpu_rdata both pass ram_rdata through. Their value is don't-care unless the matching rvalid is high.
- The CPU must not change its request while pending. After cpu_gnt the CPU may present a new request on the next cycle.
- Guard (compiled in): 8-bit wait_cnt.
  - Increments in each cycle with cpu_req && !cpu_gnt.
  - Clears on cpu_gnt or !cpu_req.
  - Force is active when wait_cnt == CPU_MAX_WAIT.
  - If disp_req=1 in a forced cycle, disp_overrun sets. It is cleared only by reset.
- Reset (RST_N low, any time): ram_en, ram_we, ram_addr, ram_wdata, disp_rvalid, cpu_rvalid, disp_overrun, wait_cnt and all tags are 0. disp_gnt and cpu_gnt are forced 0 while RST_N is low. In-flight reads are discarded and produce no rvalid after release.

## Timing
- Grant to RAM access: 1 cycle (grant in cycle t, ram_en in t+1).
- Read latency: grant in t -> rvalid and data in t+2. One read can complete per cycle; back-to-back grants give back-to-back rvalids in grant order.
- Writes: grant in t, RAM write in t+1, no rvalid.
- Simultaneous disp_req and cpu_req without force: display wins and the CPU waits. The CPU is guaranteed a slot on the first cycle with disp_req=0.
- Forced slot: at most one per CPU_MAX_WAIT+1 cycles of continuous contention.

## Configuration
- VRAM_ARB_STARVE_GUARD_EN defined: the wait counter, forced CPU slot and disp_overrun are present as described.
- Undefined: strict display priority. wait_cnt is removed, disp_overrun is tied to 0, CPU_MAX_WAIT is ignored, and the CPU can wait indefinitely while disp_req stays high.

## Test plan
- CPU-only read: cpu_req=1, addr=0x0010, RAM returns 0xBEEF. Required: cpu_gnt in t, ram_en/ram_addr=0x0010 in t+1, cpu_rvalid=1 with cpu_rdata=0xBEEF in t+2.
- Contention: disp_req and cpu_req both high for 1 cycle, then disp_req low. Required: disp_gnt in t, cpu_gnt in t+1; disp_rvalid in t+2, cpu_rvalid in t+3.
- Back-to-back display reads at addr 0..7 with RAM returning addr^0xFFFF. Required: 8 consecutive disp_rvalid starting 2 cycles after the first grant, with correct data in order.
- Guard, CPU_MAX_WAIT=4: disp_req held high, CPU write pending. Required: cpu_gnt in the 5th cycle of the wait, ram_we=1 in the next cycle, disp_overrun=1 from then on. Without the macro: no cpu_gnt while disp_req is high, and disp_overrun stays 0.
- Reset mid-read: assert RST_N low 1 cycle after a grant. Required: all outputs 0 immediately, no rvalid after release, and the next request behaves as it does from power-up.
